// File: rtl/norm_pkg.sv
// Shared command encodings and default width for the shift/accumulate control unit and its datapath.
// Pure declarations: no logic, no latency, no flow control.
package norm_pkg;

  localparam int NORM_N = 8;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_RIGHT = 2'd1,
    SH_LEFT  = 2'd2,
    SH_RSV   = 2'd3
  } sh_cmd_e;

  typedef enum logic [1:0] {
    ACC_RUN = 2'd0,
    ACC_CLR = 2'd1
  } acc_cmd_e;

endpackage

// File: rtl/norm_result_reg.sv
// Captures the normalised value once per reset and holds it on a valid/ack handshake.
// One edge from capture to res_valid; holds indefinitely until res_ack, never recaptures.
module norm_result_reg #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         capture,
  input  logic [N-1:0] value,
  input  logic         zero,
  input  logic         res_ack,
  output logic [N-1:0] dout,
  output logic         res_zero,
  output logic         res_valid
);

  logic captured;

  always_ff @(posedge clock) begin
    if (reset) begin
      dout      <= '0;
      res_zero  <= 1'b0;
      res_valid <= 1'b0;
      captured  <= 1'b0;
    end else if (capture && !captured) begin
      dout      <= value;
      res_zero  <= zero;
      res_valid <= 1'b1;
      captured  <= 1'b1;
    end else if (res_valid && res_ack) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/norm_shift_datapath.sv
// Left-normaliser driven by the control unit; k counts leading zeros, q is the live MSB.
// q/k reflect the register each edge; result held on valid/ack until the consumer accepts.
module norm_shift_datapath
  import norm_pkg::*;
#(
  parameter int N = NORM_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic [1:0]   c_sh,
  input  logic [1:0]   c_acc,
  input  logic         cont,
  input  logic         ready,
  output logic [N-1:0] k,
  output logic         q,
  output logic [N-1:0] dout,
  output logic         res_zero,
  output logic         res_valid,
  input  logic         res_ack
);

  localparam logic [N-1:0] K_MAX = N'(N);

  logic [N-1:0] work;

  // Everything freezes once ready is high, mirroring the control unit's own gating.
  always_ff @(posedge clock) begin
    if (reset) begin
      work <= '0;
      k    <= '0;
    end else if (!ready) begin
      if (c_acc == ACC_CLR) begin
        k <= '0;
        if (c_sh == SH_LEFT) work <= din;
      end else if (c_acc == ACC_RUN && c_sh == SH_LEFT && cont) begin
        work <= work << 1;
        if (k < K_MAX) k <= k + N'(1);
      end else if (c_sh == SH_RIGHT) begin
        work <= work >> 1;
      end
    end
  end

  assign q = work[N-1];

  norm_result_reg #(.N(N)) u_result (
    .clock     (clock),
    .reset     (reset),
    .capture   (ready),
    .value     (work),
    .zero      (k == K_MAX),
    .res_ack   (res_ack),
    .dout      (dout),
    .res_zero  (res_zero),
    .res_valid (res_valid)
  );

endmodule

// File: doc/norm_shift_datapath.md
Name: norm_shift_datapath

Overview:
Datapath responder for the shift/accumulate control unit. It executes the c_sh/c_acc/cont command codes that the control unit issues, and returns the k count and the q status bit that the control unit tests for termination.
The block left-normalises an N-bit operand: it shifts the operand left until its MSB is 1 or until N shifts have been made. It counts the shifts, which gives the leading-zero count.
When the control unit raises ready, the block captures the result and presents it on a valid/ack handshake to the consumer.

Parameters:
N, 8, operand width. Also the width of the k port, to match the control unit's n parameter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
din  in  N  operand; sampled on load
c_sh  in  2  shift command from control unit
c_acc  in  2  count/load command from control unit
cont  in  1  continue enable from control unit
ready  in  1  done flag from control unit; stays high until reset
k  out  N  shift count (leading zeros so far), registered
q  out  1  MSB of working register, taken combinationally from that register
dout  out  N  captured normalised value
res_zero  out  1  captured: operand was all zeros
res_valid  out  1  result available
res_ack  in  1  consumer accepts result

Behaviour:
- Reset (sync, on the clock edge when reset=1): working reg=0, k=0, q=0, dout=0, res_zero=0, res_valid=0, captured flag=0. Reset overrides every command in that cycle, including mid-shift.
- Command decode, evaluated each edge when reset=0 and ready=0, in priority order:
  - c_acc=1 and c_sh=2: LOAD. reg<=din, k<=0.
  - c_acc=1 and c_sh!=2: k<=0, reg holds.
  - c_acc=0, c_sh=2, cont=1: SHIFT. reg<=reg<<1 with zero fill; k<=k+1, saturating at N.
  - c_sh=1: shift right, zero fill, k holds. Reserved for divider reuse; the control unit does not drive this code.
  - c_sh=0 or c_sh=3, or cont=0: hold reg and k.
- q = reg[N-1]. There is no extra latency, so the control unit samples q and k from the same edge's register state.
- Sequencing with the control unit:
  - The first cycle in the cycle state carries c_sh=2, c_acc=1, so the block loads.
  - On that edge the control unit tests the pre-load k and q. These are 0 after reset, so the control unit continues.
  - Each following cycle carries c_acc=0, so the block shifts once per cycle until q=1 or k=N.
  - Total cycles from load to ready = (leading zeros)+1, with the leading-zero count capped at N.
- Result capture: on the first edge with ready=1 and captured=0, set dout<=reg, res_zero<=(k==N), res_valid<=1, captured<=1.
- While ready=1, reg and k are frozen, matching the control unit's gating.
- Handshake:
  - res_valid stays high and dout/res_zero stay stable until an edge with res_valid=1 and res_ack=1. On that edge res_valid<=0.
  - res_ack while res_valid=0 is ignored.
  - There is no recapture while captured=1. Only reset clears captured.
- k width is N bits. The arithmetic uses k<N as the saturation guard and never wraps.

Decomposition:
- Package norm_pkg holds:
  - c_sh encodings as a 2-bit enum: SH_HOLD=0, SH_RIGHT=1, SH_LEFT=2, SH_RSV=3.
  - c_acc encodings: ACC_RUN=0, ACC_CLR=1.
  - The shared default N.
  - The same package is imported by control_unit users.
- Sub-module: norm_result_reg, holding the capture register and the valid/ack handshake. The shift register and counter stay in the top-level module.

Test Plan:
- Normal operand: reset, then din=8'b0001_0110 with the control sequence for one load and 3 shifts. Expect q=1 after the 3rd shift, then ready. Expect dout=8'b1011_0000, k=3, res_zero=0, res_valid=1.
- MSB already set: din=8'h80. Expect q=1 immediately after load, k=0, dout=8'h80, and ready one cycle after load.
- Zero operand: din=8'h00. Expect 8 shifts with k saturating at 8 (no wrap to 0), q=0 throughout, dout=0, res_zero=1.
- Handshake: after capture, hold res_ack=0 for 5 cycles. Expect res_valid=1 and dout stable throughout. Pulse res_ack=1 for one cycle: expect res_valid=0 on the next edge, and no recapture while ready stays 1.
- Reset mid-operation: din=8'h01, assert reset after 2 shifts. Expect reg=0, k=0, q=0, res_valid=0 on the next edge. Rerun with din=8'h01: expect k=7, dout=8'h80.
- Command corners: c_acc=1 with c_sh=0 clears k without loading; c_sh=2, c_acc=0, cont=0 holds reg and k; c_sh=3 holds.
